// File: rtl/lifo_mc_pkg.sv
// Shared constants, channel-width helper and op-decode type for the multi-channel LIFO.
package lifo_mc_pkg;
  localparam int DWIDTH_DEF       = 16;
  localparam int AWIDTH_DEF       = 8;
  localparam int CHANNELS_DEF     = 4;
  localparam int ALMOST_FULL_DEF  = 2;
  localparam int ALMOST_EMPTY_DEF = 2;

  function automatic int chan_w(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
    logic same_ch;
  } op_dec_t;
endpackage

// File: rtl/lifo_mc_ram.sv
// Simple dual-port RAM, read-first, registered read port.
module lifo_mc_ram #(
  parameter int DWIDTH = 16,
  parameter int ABITS  = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ABITS-1:0]  waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [ABITS-1:0]  raddr,
  output logic [DWIDTH-1:0] q
);
  logic [DWIDTH-1:0] mem [DEPTH];

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of mem sees the pre-write word on a same-address cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/lifo_mc.sv
// Multi-channel LIFO: CHANNELS stacks sharing one RAM, one push and one pop per cycle.
module lifo_mc
  import lifo_mc_pkg::*;
#(
  parameter int DWIDTH       = DWIDTH_DEF,
  parameter int AWIDTH       = AWIDTH_DEF,
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int ALMOST_FULL  = ALMOST_FULL_DEF,
  parameter int ALMOST_EMPTY = ALMOST_EMPTY_DEF,
  localparam int CW          = chan_w(CHANNELS)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [CHANNELS-1:0]              flush_i,
  input  logic                             wrreq_i,
  input  logic [CW-1:0]                    wr_ch_i,
  input  logic [DWIDTH-1:0]                data_i,
  input  logic                             rdreq_i,
  input  logic [CW-1:0]                    rd_ch_i,
  output logic [DWIDTH-1:0]                q_o,
  output logic                             q_valid_o,
  output logic [CW-1:0]                    q_ch_o,
  output logic [CHANNELS-1:0]              empty_o,
  output logic [CHANNELS-1:0]              almost_empty_o,
  output logic [CHANNELS-1:0]              full_o,
  output logic [CHANNELS-1:0]              almost_full_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0]   usedw_o,
  output logic [CHANNELS-1:0]              ovf_o,
  output logic [CHANNELS-1:0]              udf_o
);
  localparam int CNTW = AWIDTH + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(2**AWIDTH);
  localparam logic [CNTW-1:0] AF_CNT   = CNTW'(2**AWIDTH - ALMOST_FULL);
  localparam logic [CNTW-1:0] AE_CNT   = CNTW'(ALMOST_EMPTY);

  logic [CNTW-1:0]   cnt [CHANNELS];
  logic              wr_in, rd_in;
  logic [CNTW-1:0]   wr_cnt, rd_cnt;
  logic [AWIDTH-1:0] wr_slot, rd_slot;
  logic              ovf, udf;
  op_dec_t           dec;

  assign wr_in  = {1'b0, wr_ch_i} < (CW+1)'(CHANNELS);
  assign rd_in  = {1'b0, rd_ch_i} < (CW+1)'(CHANNELS);
  assign wr_cnt = wr_in ? cnt[wr_ch_i] : '0;
  assign rd_cnt = rd_in ? cnt[rd_ch_i] : '0;

  // Flush wins over both ops; a same-channel push on a non-empty stack replaces the top.
  always_comb begin
    dec         = '0;
    dec.same_ch = wrreq_i && rdreq_i && (wr_ch_i == rd_ch_i);
    dec.rd_ok   = rdreq_i && rd_in && !flush_i[rd_ch_i] && (rd_cnt != '0);
    dec.wr_ok   = wrreq_i && wr_in && !flush_i[wr_ch_i] &&
                  ((wr_cnt != FULL_CNT) || (dec.same_ch && dec.rd_ok));
    ovf         = wrreq_i && wr_in && !flush_i[wr_ch_i] && !dec.wr_ok;
    udf         = rdreq_i && rd_in && !flush_i[rd_ch_i] && (rd_cnt == '0);
  end

  assign rd_slot = rd_cnt[AWIDTH-1:0] - 1'b1;
  assign wr_slot = wr_cnt[AWIDTH-1:0] - AWIDTH'(dec.same_ch && dec.rd_ok);

  lifo_mc_ram #(
    .DWIDTH (DWIDTH),
    .ABITS  (CW + AWIDTH),
    .DEPTH  (CHANNELS * (2**AWIDTH))
  ) u_ram (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .we    (dec.wr_ok),
    .waddr ({wr_ch_i, wr_slot}),
    .wdata (data_i),
    .re    (dec.rd_ok),
    .raddr ({rd_ch_i, rd_slot}),
    .q     (q_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush_i[c])
          cnt[c] <= '0;
        else if (dec.wr_ok && wr_ch_i == CW'(c) && !(dec.rd_ok && rd_ch_i == CW'(c)))
          cnt[c] <= cnt[c] + 1'b1;
        else if (dec.rd_ok && rd_ch_i == CW'(c) && !(dec.wr_ok && wr_ch_i == CW'(c)))
          cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_valid_o <= 1'b0;
      q_ch_o    <= '0;
      ovf_o     <= '0;
      udf_o     <= '0;
    end else begin
      q_valid_o <= dec.rd_ok;
      if (dec.rd_ok) q_ch_o <= rd_ch_i;
      ovf_o <= ovf ? (CHANNELS'(1) << wr_ch_i) : '0;
      udf_o <= udf ? (CHANNELS'(1) << rd_ch_i) : '0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_flag
    assign empty_o[c]               = (cnt[c] == '0);
    assign full_o[c]                = (cnt[c] == FULL_CNT);
    assign almost_full_o[c]         = (cnt[c] >= AF_CNT);
    assign almost_empty_o[c]        = (cnt[c] <= AE_CNT);
    assign usedw_o[c*CNTW +: CNTW]  = cnt[c];
  end
endmodule

// File: tb/tb_lifo_mc.sv
// Bench for lifo_mc: per-channel stacks modelled as queues, directed plan plus random traffic.
module tb_lifo_mc;
  localparam int DW = 16, AW = 3, CH = 4, CW = 2, D = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0] flush = '0;
  logic          wrreq = 1'b0, rdreq = 1'b0;
  logic [CW-1:0] wr_ch = '0, rd_ch = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] q;
  logic          q_valid;
  logic [CW-1:0] q_ch;
  logic [CH-1:0] empty, almost_empty, full, almost_full, ovf, udf;
  logic [CH*(AW+1)-1:0] usedw;

  int checks = 0, errors = 0;

  // Reference state: one queue per channel, back = top of stack.
  logic [DW-1:0] stk [CH][$];
  logic          exp_qv;
  logic [DW-1:0] exp_q;
  logic [CW-1:0] exp_qch;
  logic [CH-1:0] exp_ovf, exp_udf;

  lifo_mc #(.DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .ALMOST_FULL(2), .ALMOST_EMPTY(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .wrreq_i(wrreq), .wr_ch_i(wr_ch),
    .data_i(data), .rdreq_i(rdreq), .rd_ch_i(rd_ch), .q_o(q), .q_valid_o(q_valid),
    .q_ch_o(q_ch), .empty_o(empty), .almost_empty_o(almost_empty), .full_o(full),
    .almost_full_o(almost_full), .usedw_o(usedw), .ovf_o(ovf), .udf_o(udf));

  always #5 clk = ~clk;

  function automatic logic [8*CH-1:0] exp_status();
    logic [8*CH-1:0] s;
    int n;
    s = '0;
    for (int c = 0; c < CH; c++) begin
      n = stk[c].size();
      s[7*CH + c] = (n == 0);
      s[6*CH + c] = (n <= 2);
      s[5*CH + c] = (n == D);
      s[4*CH + c] = (n >= D - 2);
      s[c*4 +: 4] = 4'(n);
    end
    return s;
  endfunction

  function automatic int cnt_of(input int c);
    return int'(usedw[c*4 +: 4]);
  endfunction

  // Drives one cycle of requests and advances the model; leaves us at the following negedge.
  task automatic cycle(input logic [CH-1:0] fl, input logic wr, input logic [CW-1:0] wc,
                       input logic [DW-1:0] wd, input logic rd, input logic [CW-1:0] rc);
    flush = fl; wrreq = wr; wr_ch = wc; data = wd; rdreq = rd; rd_ch = rc;
    exp_qv = 1'b0; exp_ovf = '0; exp_udf = '0;
    if (rd && !fl[rc]) begin
      if (stk[rc].size() == 0) exp_udf[rc] = 1'b1;
      else begin exp_q = stk[rc].pop_back(); exp_qch = rc; exp_qv = 1'b1; end
    end
    if (wr && !fl[wc]) begin
      if (stk[wc].size() < D) stk[wc].push_back(wd);
      else exp_ovf[wc] = 1'b1;
    end
    for (int c = 0; c < CH; c++) if (fl[c]) stk[c].delete();
    @(posedge clk);
    @(negedge clk);
    flush = '0; wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({empty, almost_empty, full, almost_full, usedw} !== exp_status()) begin
      errors++; $display("FAIL reset_status got %h exp %h", {empty, almost_empty, full, almost_full, usedw}, exp_status());
    end
    checks++;
    if ({q, q_valid, q_ch, ovf, udf} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {q, q_valid, q_ch, ovf, udf});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      cycle('0, 1'b1, 2'd1, DW'(16'h100 + i), 1'b0, 2'd0);
      checks++;
      if (ovf !== (i == 8 ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL fill_ovf push %0d got %b", i, ovf);
      end
      checks++;
      if (almost_full[1] !== (i >= 5)) begin
        errors++; $display("FAIL fill_af push %0d got %b exp %b", i, almost_full[1], i >= 5);
      end
    end
    checks++;
    if (cnt_of(1) !== 8 || full[1] !== 1'b1 || empty !== 4'b1101) begin
      errors++; $display("FAIL fill_full cnt %0d full %b empty %b", cnt_of(1), full[1], empty);
    end
    for (int i = 0; i < 8; i++) begin
      cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd1);
      checks++;
      if (q_valid !== 1'b1 || q !== DW'(16'h107 - i) || q_ch !== 2'd1) begin
        errors++; $display("FAIL fill_pop %0d got v%b q %h ch %0d exp q %h", i, q_valid, q, q_ch, 16'h107 - i);
      end
    end
    checks++;
    if ({empty, almost_empty, full, almost_full, usedw} !== exp_status()) begin
      errors++; $display("FAIL fill_end_status got %h exp %h", {empty, almost_empty, full, almost_full, usedw}, exp_status());
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd2);
      checks++;
      if (udf !== 4'b0100 || q_valid !== 1'b0 || cnt_of(2) !== 0) begin
        errors++; $display("FAIL udf_%0d got udf %b v %b cnt %0d", i, udf, q_valid, cnt_of(2));
      end
    end
  endtask

  task automatic test_interleave();
    cycle('0, 1'b1, 2'd0, 16'hA, 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd3, 16'hB, 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd0, 16'hC, 1'b1, 2'd3);
    checks++;
    if (q_valid !== 1'b1 || q !== 16'hB || q_ch !== 2'd3) begin
      errors++; $display("FAIL inter_pop got v%b q %h ch %0d exp 1 000b 3", q_valid, q, q_ch);
    end
    checks++;
    if (cnt_of(0) !== 2 || cnt_of(3) !== 0) begin
      errors++; $display("FAIL inter_cnt got %0d %0d exp 2 0", cnt_of(0), cnt_of(3));
    end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    checks++;
    if (q !== 16'hC) begin errors++; $display("FAIL inter_pop0a got %h exp 000c", q); end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    checks++;
    if (q !== 16'hA) begin errors++; $display("FAIL inter_pop0b got %h exp 000a", q); end
  endtask

  task automatic test_same_ch();
    cycle('0, 1'b1, 2'd0, 16'h1, 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd0, 16'h2, 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd0, 16'h9, 1'b1, 2'd0);
    checks++;
    if (q !== 16'h2 || q_valid !== 1'b1 || cnt_of(0) !== 2) begin
      errors++; $display("FAIL same_pop got q %h v %b cnt %0d exp 0002 1 2", q, q_valid, cnt_of(0));
    end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    checks++;
    if (q !== 16'h9) begin errors++; $display("FAIL same_next got %h exp 0009", q); end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    checks++;
    if (q !== 16'h1) begin errors++; $display("FAIL same_last got %h exp 0001", q); end
    for (int i = 0; i < D; i++) cycle('0, 1'b1, 2'd0, DW'(16'h50 + i), 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd0, 16'h77, 1'b1, 2'd0);
    checks++;
    if (ovf !== 4'b0 || q !== 16'h57 || cnt_of(0) !== 8 || full[0] !== 1'b1) begin
      errors++; $display("FAIL same_full got ovf %b q %h cnt %0d", ovf, q, cnt_of(0));
    end
    cycle('0, 1'b0, 2'd0, '0, 1'b1, 2'd0);
    checks++;
    if (q !== 16'h77) begin errors++; $display("FAIL same_full_top got %h exp 0077", q); end
    cycle(4'b0001, 1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle('0, 1'b1, 2'd1, DW'(i), 1'b0, 2'd0);
    cycle(4'b0010, 1'b1, 2'd2, 16'h33, 1'b1, 2'd1);
    checks++;
    if (q_valid !== 1'b0 || udf !== 4'b0 || cnt_of(1) !== 0 || empty[1] !== 1'b1 || cnt_of(2) !== 1) begin
      errors++; $display("FAIL flush got v%b udf %b cnt1 %0d e %b cnt2 %0d", q_valid, udf, cnt_of(1), empty[1], cnt_of(2));
    end
    cycle(4'b0100, 1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_random();
    logic [CH-1:0] fl;
    for (int n = 0; n < 600; n++) begin
      fl = ($urandom_range(0, 19) == 0) ? CH'($urandom) : '0;
      cycle(fl, 1'($urandom_range(0, 2) != 0), CW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) != 0), CW'($urandom));
      checks++;
      if (q_valid !== exp_qv || ovf !== exp_ovf || udf !== exp_udf ||
          (exp_qv && (q !== exp_q || q_ch !== exp_qch))) begin
        errors++; $display("FAIL rand_out %0d got v%b q %h ch %0d ovf %b udf %b exp v%b q %h ch %0d ovf %b udf %b",
          n, q_valid, q, q_ch, ovf, udf, exp_qv, exp_q, exp_qch, exp_ovf, exp_udf);
      end
      checks++;
      if ({empty, almost_empty, full, almost_full, usedw} !== exp_status()) begin
        errors++; $display("FAIL rand_status %0d got %h exp %h", n, {empty, almost_empty, full, almost_full, usedw}, exp_status());
      end
    end
  endtask

  task automatic test_async_reset();
    logic [CW-1:0] c;
    for (int i = 0; i < 4; i++) cycle('0, 1'b1, 2'd3, DW'(16'hF0 + i), 1'b0, 2'd0);
    cycle('0, 1'b1, 2'd0, 16'h5, 1'b1, 2'd3);
    #2 rst_n = 1'b0;
    for (int k = 0; k < CH; k++) stk[k].delete();
    #1;
    checks++;
    if ({empty, almost_empty, full, almost_full, usedw} !== exp_status() ||
        {q, q_valid, q_ch, ovf, udf} !== '0) begin
      errors++; $display("FAIL async_reset got %h %h", {empty, almost_empty, full, almost_full, usedw}, {q, q_valid, q_ch, ovf, udf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = CW'($urandom);
    cycle('0, 1'b0, 2'd0, '0, 1'b1, c);
    checks++;
    if (udf !== (4'b1 << c) || q_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_udf ch %0d got %b v %b", c, udf, q_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_interleave();
    test_same_ch();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
